// File: rtl/tri_raster_scan_pkg.sv
// Shared types, FSM encoding and arithmetic helpers for the triangle raster scanner.
package tri_raster_scan_pkg;

  // Internal coordinate width. The top-level COORD_W must not exceed it.
  localparam int CW = 16;
  localparam int EW = 2 * CW + 3;

  typedef logic signed [CW-1:0] coord_t;
  typedef logic signed [EW-1:0] ew_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    INIT  = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } raster_state_e;

  typedef struct packed {
    ew_t a;
    ew_t b;
    ew_t c;
  } edge_coef_t;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic ew_t edge_eval(edge_coef_t e, coord_t x, coord_t y);
    return e.a * ew_t'(x) + e.b * ew_t'(y) + e.c;
  endfunction

  function automatic edge_coef_t edge_negate(edge_coef_t e);
    edge_coef_t n;
    n.a = -e.a;
    n.b = -e.b;
    n.c = -e.c;
    return n;
  endfunction

endpackage

// File: rtl/tri_raster_scan_edge_setup.sv
// Combinational edge-function coefficients for the directed edge (x0,y0)->(x1,y1).
module tri_edge_setup
  import tri_raster_scan_pkg::*;
(
  input  logic signed [CW-1:0] x0,
  input  logic signed [CW-1:0] y0,
  input  logic signed [CW-1:0] x1,
  input  logic signed [CW-1:0] y1,
  output logic signed [EW-1:0] a,
  output logic signed [EW-1:0] b,
  output logic signed [EW-1:0] c
);

  // C is chosen so that E = A*x + B*y + C vanishes at both edge endpoints.
  always_comb begin
    a = ew_t'(y1) - ew_t'(y0);
    b = ew_t'(x0) - ew_t'(x1);
    c = ew_t'(x1) * ew_t'(y0) - ew_t'(x0) * ew_t'(y1);
  end

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle rasteriser: bbox setup, row-major incremental edge walk, pixel stream.
// Optional back-face culling is enabled by defining TRI_RASTER_BACKFACE_CULL_EN.
module tri_raster_scan
  import tri_raster_scan_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic [2*COORD_W-1:0] tri_p,
  input  logic [2*COORD_W-1:0] tri_q,
  input  logic [2*COORD_W-1:0] tri_r,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic                 tri_done,
`ifdef TRI_RASTER_BACKFACE_CULL_EN
  output logic                 tri_culled,
`endif
  output logic [2:0]           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once valid is raised, it and its payload hold until that transfer.

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SETUP = SETUP;
  localparam logic [2:0] S_INIT  = INIT;
  localparam logic [2:0] S_SCAN  = SCAN;
  localparam logic [2:0] S_DONE  = DONE;

  localparam coord_t X_END = coord_t'(SCREEN_W);
  localparam coord_t Y_END = coord_t'(SCREEN_H);
  localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

  function automatic coord_t ext(logic [COORD_W-1:0] v);
    return coord_t'(signed'(v));
  endfunction

  logic [2:0]  state_q;
  coord_t      vx [3];
  coord_t      vy [3];
  edge_coef_t  coef_q [3];
  ew_t         e_q [3];
  ew_t         row_q [3];
  coord_t      xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t      x_q, y_q;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
  logic        cull_q;
`endif

  edge_coef_t  coef_w [3];
  ew_t         ca [3];
  ew_t         cb [3];
  ew_t         cc [3];

  for (genvar i = 0; i < 3; i++) begin : g_edge
    tri_edge_setup u_edge (
      .x0 (vx[i]),
      .y0 (vy[i]),
      .x1 (vx[(i + 1) % 3]),
      .y1 (vy[(i + 1) % 3]),
      .a  (ca[i]),
      .b  (cb[i]),
      .c  (cc[i])
    );
    assign coef_w[i] = '{a: ca[i], b: cb[i], c: cc[i]};
  end

  ew_t    area;
  coord_t bx_lo, bx_hi, by_lo, by_hi;
  coord_t cx_lo, cx_hi, cy_lo, cy_hi;
  logic   box_empty;

  always_comb begin
    area      = edge_eval(coef_w[0], vx[2], vy[2]);
    bx_lo     = min3(vx[0], vx[1], vx[2]);
    bx_hi     = max3(vx[0], vx[1], vx[2]);
    by_lo     = min3(vy[0], vy[1], vy[2]);
    by_hi     = max3(vy[0], vy[1], vy[2]);
    cx_lo     = bx_lo[CW-1] ? '0 : bx_lo;
    cy_lo     = by_lo[CW-1] ? '0 : by_lo;
    cx_hi     = (bx_hi > X_MAX) ? X_MAX : bx_hi;
    cy_hi     = (by_hi > Y_MAX) ? Y_MAX : by_hi;
    box_empty = bx_hi[CW-1] || by_hi[CW-1] || (bx_lo >= X_END) || (by_lo >= Y_END);
  end

  logic covered, out_free, advance, at_row_end, at_last;

  always_comb begin
    covered    = !e_q[0][EW-1] && !e_q[1][EW-1] && !e_q[2][EW-1];
    out_free   = !pix_valid || pix_ready;
    advance    = (state_q == S_SCAN) && (!covered || out_free);
    at_row_end = (x_q == xmax_q);
    at_last    = at_row_end && (y_q == ymax_q);
  end

  assign tri_ready = (state_q == S_IDLE);
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      tri_done  <= 1'b0;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
      tri_culled <= 1'b0;
      cull_q     <= 1'b0;
`endif
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i]     <= '0;
        vy[i]     <= '0;
        coef_q[i] <= '0;
        e_q[i]    <= '0;
        row_q[i]  <= '0;
      end
    end else begin
      tri_done <= 1'b0;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
      tri_culled <= 1'b0;
`endif
      if (pix_valid && pix_ready) pix_valid <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tri_valid) begin
            vx[0]   <= ext(tri_p[2*COORD_W-1:COORD_W]);
            vy[0]   <= ext(tri_p[COORD_W-1:0]);
            vx[1]   <= ext(tri_q[2*COORD_W-1:COORD_W]);
            vy[1]   <= ext(tri_q[COORD_W-1:0]);
            vx[2]   <= ext(tri_r[2*COORD_W-1:COORD_W]);
            vy[2]   <= ext(tri_r[COORD_W-1:0]);
`ifdef TRI_RASTER_BACKFACE_CULL_EN
            cull_q  <= 1'b0;
`endif
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          xmin_q <= cx_lo;
          xmax_q <= cx_hi;
          ymin_q <= cy_lo;
          ymax_q <= cy_hi;
          // Normalise winding so the inside is always where all three E >= 0.
          for (int i = 0; i < 3; i++)
            coef_q[i] <= area[EW-1] ? edge_negate(coef_w[i]) : coef_w[i];
          if (area == '0 || box_empty) begin
            state_q <= S_DONE;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
          end else if (area[EW-1]) begin
            cull_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_INIT;
          end
        end

        S_INIT: begin
          x_q <= xmin_q;
          y_q <= ymin_q;
          for (int i = 0; i < 3; i++) begin
            e_q[i]   <= edge_eval(coef_q[i], xmin_q, ymin_q);
            row_q[i] <= edge_eval(coef_q[i], xmin_q, ymin_q);
          end
          state_q <= S_SCAN;
        end

        S_SCAN: begin
          if (advance) begin
            if (covered) begin
              pix_valid <= 1'b1;
              pix_x     <= COORD_W'(x_q);
              pix_y     <= COORD_W'(y_q);
            end
            if (at_last) begin
              state_q <= S_DONE;
            end else if (at_row_end) begin
              x_q <= xmin_q;
              y_q <= y_q + coord_t'(1);
              for (int i = 0; i < 3; i++) begin
                row_q[i] <= row_q[i] + coef_q[i].b;
                e_q[i]   <= row_q[i] + coef_q[i].b;
              end
            end else begin
              x_q <= x_q + coord_t'(1);
              for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + coef_q[i].a;
            end
          end
        end

        S_DONE: begin
          // Finish only once the last pixel has left the output register.
          if (out_free) begin
            tri_done <= 1'b1;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
            tri_culled <= cull_q;
`endif
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed testbench for tri_raster_scan (default 640x480 screen, 16-bit coordinates).
module tb_tri_raster_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [31:0] tri_p = '0;
  logic [31:0] tri_q = '0;
  logic [31:0] tri_r = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        tri_done;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
  logic        tri_culled;
`endif
  logic [2:0]  fsm_state;

  tri_raster_scan #(.COORD_W(16), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_p     (tri_p),
    .tri_q     (tri_q),
    .tri_r     (tri_r),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .tri_done  (tri_done),
`ifdef TRI_RASTER_BACKFACE_CULL_EN
    .tri_culled(tri_culled),
`endif
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  int   first_cyc;
  int   done_cyc;
  int   npix;
  logic culled_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    return {16'(x), 16'(y)};
  endfunction

  task automatic push_basic();
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x <= 4; x++)
        if (x + y <= 4) exp_q.push_back(pt(x, y));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_tri_done"}, 32'(tri_done), 32'd0);
    check({tag, "_tri_ready"}, 32'(tri_ready), 32'd1);
`ifdef TRI_RASTER_BACKFACE_CULL_EN
    check({tag, "_tri_culled"}, 32'(tri_culled), 32'd0);
`endif
  endtask

  // Drive one triangle and follow it to tri_done; abort_at>0 resets after that many pixels.
  task automatic run_tri(input int px, input int py, input int qx, input int qy,
                         input int rx, input int ry, input bit bp, input int abort_at);
    logic [31:0] held;
    bit          holding;
    int          cyc;
    @(negedge clk);
    check("tri_ready_before_accept", 32'(tri_ready), 32'd1);
    tri_p = pt(px, py);
    tri_q = pt(qx, qy);
    tri_r = pt(rx, ry);
    tri_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tri_valid = 1'b0;
    cyc = 0;
    first_cyc = -1;
    done_cyc = -1;
    npix = 0;
    holding = 1'b0;
    culled_at_done = 1'b0;
    while (cyc < 400) begin
      if (tri_done) begin
        done_cyc = cyc;
`ifdef TRI_RASTER_BACKFACE_CULL_EN
        culled_at_done = tri_culled;
`endif
        break;
      end
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding) begin
        check("stall_valid_held", 32'(pix_valid), 32'd1);
        check("stall_pixel_held", {pix_x, pix_y}, held);
      end
      holding = 1'b0;
      if (pix_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pix_ready) begin
          npix++;
          if (exp_q.size() == 0) check("unexpected_pixel", {pix_x, pix_y}, 32'hffff_ffff);
          else check("pixel", {pix_x, pix_y}, exp_q.pop_front());
          if (npix == abort_at) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 check_reset_outputs("midscan_rst");
            exp_q.delete();
            pix_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("tri_ready_after_rst", 32'(tri_ready), 32'd1);
            check("no_done_after_rst", 32'(tri_done), 32'd0);
            return;
          end
        end else begin
          holding = 1'b1;
          held = {pix_x, pix_y};
        end
      end
      @(negedge clk);
      cyc++;
    end
    pix_ready = 1'b1;
    if (done_cyc < 0) check("tri_done_timeout", 32'(tri_done), 32'd1);
    check("missing_pixels", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state.
    #2 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic triangle, area +16, ready held high.
    push_basic();
    run_tri(0, 0, 0, 4, 4, 0, 1'b0, 0);
    check("basic_count", 32'(npix), 32'd15);
    check("basic_first_latency", 32'(first_cyc), 32'd3);
    check("basic_done_latency", 32'(done_cyc), 32'd28);
    check("basic_ready_after", 32'(tri_ready), 32'd1);

    // Reverse winding.
`ifdef TRI_RASTER_BACKFACE_CULL_EN
    run_tri(0, 0, 4, 0, 0, 4, 1'b0, 0);
    check("reverse_count", 32'(npix), 32'd0);
    check("reverse_culled", 32'(culled_at_done), 32'd1);
    check("reverse_done_latency", 32'(done_cyc), 32'd2);
`else
    push_basic();
    run_tri(0, 0, 4, 0, 0, 4, 1'b0, 0);
    check("reverse_count", 32'(npix), 32'd15);
    check("reverse_first_latency", 32'(first_cyc), 32'd3);
`endif

    // Degenerate (collinear) triangle.
    run_tri(1, 1, 3, 3, 5, 5, 1'b0, 0);
    check("degen_count", 32'(npix), 32'd0);
    check("degen_done_latency", 32'(done_cyc), 32'd2);
    check("degen_not_culled", 32'(culled_at_done), 32'd0);

    // Clamped box with no covered pixel on screen.
    run_tri(-10, -10, -10, 5, 5, -10, 1'b0, 0);
    check("clamp_none_count", 32'(npix), 32'd0);

    // Clamped box keeping three corner pixels.
    exp_q.push_back(pt(0, 0));
    exp_q.push_back(pt(1, 0));
    exp_q.push_back(pt(0, 1));
    run_tri(-2, -2, -2, 3, 3, -2, 1'b0, 0);
    check("clamp_corner_count", 32'(npix), 32'd3);

    // Clipped against the right screen edge (x <= 639).
    for (int y = 0; y <= 5; y++)
      for (int x = 637; x <= 639; x++)
        if ((x - 637) + y <= 5) exp_q.push_back(pt(x, y));
    run_tri(637, 0, 637, 5, 642, 0, 1'b0, 0);
    check("right_clip_count", 32'(npix), 32'd15);

    // Entirely right of the screen: empty box.
    run_tri(700, 0, 700, 5, 705, 0, 1'b0, 0);
    check("offscreen_count", 32'(npix), 32'd0);
    check("offscreen_done_latency", 32'(done_cyc), 32'd2);

    // Backpressure with random pix_ready.
    push_basic();
    run_tri(0, 0, 0, 4, 4, 0, 1'b1, 0);
    check("bp_count", 32'(npix), 32'd15);

    // Reset after the 5th pixel, then a clean triangle.
    push_basic();
    run_tri(0, 0, 0, 4, 4, 0, 1'b0, 5);
    push_basic();
    run_tri(0, 0, 0, 4, 4, 0, 1'b0, 0);
    check("post_rst_count", 32'(npix), 32'd15);
    check("post_rst_first_latency", 32'(first_cyc), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
